// File: rtl/perm_mem_pkg.sv
// Shared types and constants for the two-lane stride-2 permutation buffer.
// Defaults describe the reference configuration (32-bit words, 8-word frames).
package perm_mem_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LOGN_DEF  = 3;
  localparam int N         = 1 << LOGN_DEF;
  localparam int HALF      = N / 2;
  localparam int ADDR_W    = LOGN_DEF;
  localparam int CNT_W     = LOGN_DEF - 1;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Both FSM state registers live in one struct so the current control state
  // can be probed as a single signal.
  typedef struct packed {
    wr_state_e wr;
    rd_state_e rd;
  } fsm_state_t;

  // Stride-2 source index for the reference frame size: a left rotate by one
  // bit turns output position j into the input word index it carries.
  function automatic logic [ADDR_W-1:0] perm_stride2(input logic [ADDR_W-1:0] j);
    return {j[ADDR_W-2:0], j[ADDR_W-1]};
  endfunction

endpackage

// File: rtl/perm_addr_gen.sv
// Read address generator: maps read cycle c' to the two bank addresses
// holding output positions 2c' and 2c'+1 of the stride-2 order.
module perm_addr_gen #(
  parameter int LOGN = 3
) (
  input  logic [LOGN-2:0] rd_cnt,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1
);

  logic [LOGN-1:0] pos0;
  logic [LOGN-1:0] pos1;

  // Output position j maps to input word {j[LOGN-2:0], j[LOGN-1]}: the top bit
  // selects even/odd half, the rest selects the pair. Pure wiring, no adders.
  always_comb begin
    pos0     = {rd_cnt, 1'b0};
    pos1     = {rd_cnt, 1'b1};
    rd_addr0 = {pos0[LOGN-2:0], pos0[LOGN-1]};
    rd_addr1 = {pos1[LOGN-2:0], pos1[LOGN-1]};
  end

endmodule

// File: rtl/perm_mem_2lane.sv
// Two-lane streaming stride-2 permutation buffer with ping-pong banks.
// A frame of 2^LOGN words arrives two per cycle and leaves in stride-2 order
// (even-indexed words first, then odd) with a fixed next->next_out latency
// of N/2+1 cycles. Optional feature macro: PERM_OVERRUN_FLAG_EN adds a sticky
// overrun output that records any next pulse ignored mid-frame.
//
// Framing: next is a one-cycle pulse and the first input pair is presented on
// the following cycle, then one pair per cycle for N/2 cycles with no stalls.
// next_out mirrors this on the output side: a one-cycle pulse followed by N/2
// consecutive output pairs. There is no backpressure in either direction.
module perm_mem_2lane
  import perm_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LOGN  = LOGN_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             next,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic             next_out,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
`ifdef PERM_OVERRUN_FLAG_EN
  ,
  output logic             overrun
`endif
);

  localparam int FRAME_N = 1 << LOGN;
  localparam int AW      = LOGN;
  localparam int CW      = LOGN - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((FRAME_N / 2) - 1);

  fsm_state_t       fsm_q;
  fsm_state_t       fsm_d;
  logic [CW-1:0]    wr_cnt_q;
  logic [CW-1:0]    rd_cnt_q;
  logic             wsel_q;
  logic             rsel_q;
  logic             wr_last;
  logic             rd_last;
  logic             rd_start;
  logic [AW-1:0]    wr_addr0;
  logic [AW-1:0]    wr_addr1;
  logic [AW-1:0]    rd_addr0;
  logic [AW-1:0]    rd_addr1;
  logic [WIDTH-1:0] mem [2][FRAME_N];

  assign wr_last  = (fsm_q.wr == WR_WRITE) && (wr_cnt_q == CNT_LAST);
  assign rd_last  = (fsm_q.rd == RD_READ) && (rd_cnt_q == CNT_LAST);
  // The cycle after the last write, that bank is complete and can be read.
  assign rd_start = wr_last;
  assign wr_addr0 = {wr_cnt_q, 1'b0};
  assign wr_addr1 = {wr_cnt_q, 1'b1};

  perm_addr_gen #(
    .LOGN(LOGN)
  ) u_addr_gen (
    .rd_cnt  (rd_cnt_q),
    .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1)
  );

  // Next-state logic for the write and read FSMs. A next pulse is honoured
  // only when idle or on the last write cycle (back-to-back frames).
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q.wr)
      WR_IDLE:  if (next) fsm_d.wr = WR_WRITE;
      WR_WRITE: if (wr_last) fsm_d.wr = next ? WR_WRITE : WR_IDLE;
      default:  fsm_d.wr = WR_IDLE;
    endcase
    case (fsm_q.rd)
      RD_IDLE: if (rd_start) fsm_d.rd = RD_READ;
      RD_READ: if (rd_last) fsm_d.rd = rd_start ? RD_READ : RD_IDLE;
      default: fsm_d.rd = RD_IDLE;
    endcase
  end

  // Control state: FSMs, counters, bank selects and the next_out pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= '{wr: WR_IDLE, rd: RD_IDLE};
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      next_out <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      // Counters run only while active; power-of-two size makes the
      // increment wrap N/2-1 -> 0 on its own.
      wr_cnt_q <= (fsm_q.wr == WR_WRITE) ? wr_cnt_q + 1'b1 : '0;
      rd_cnt_q <= (fsm_q.rd == RD_READ) ? rd_cnt_q + 1'b1 : '0;
      if (wr_last) wsel_q <= ~wsel_q;
      if (rd_start) rsel_q <= wsel_q;
      next_out <= rd_start;
    end
  end

  // Bank storage: both lanes land in the bank being filled. Not reset.
  always_ff @(posedge clk) begin
    if (fsm_q.wr == WR_WRITE) begin
      mem[wsel_q][wr_addr0] <= x0;
      mem[wsel_q][wr_addr1] <= x1;
    end
  end

  // Registered outputs: update only while reading, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y0 <= '0;
      y1 <= '0;
    end else if (fsm_q.rd == RD_READ) begin
      y0 <= mem[rsel_q][rd_addr0];
      y1 <= mem[rsel_q][rd_addr1];
    end
  end

`ifdef PERM_OVERRUN_FLAG_EN
  logic next_ignored;

  assign next_ignored = next && (fsm_q.wr == WR_WRITE) && !wr_last;

  // Sticky record of a next pulse dropped while a frame was being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (next_ignored) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_perm_mem_2lane.sv
// Testbench for perm_mem_2lane: one 8-word instance for directed frames and
// one 16-word instance for random back-to-back and gapped streams.
module tb_perm_mem_2lane;

  localparam int W      = 32;
  localparam int LOGN_A = perm_mem_pkg::CNT_W + 1;
  localparam int N_A    = perm_mem_pkg::N;
  localparam int H_A    = perm_mem_pkg::HALF;
  localparam int LOGN_B = 4;
  localparam int H_B    = 1 << (LOGN_B - 1);
  localparam int NMAX   = 2 * H_B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         reset_n    [2];
  logic         next_v     [2];
  logic [W-1:0] x0_v       [2];
  logic [W-1:0] x1_v       [2];
  logic         next_out_v [2];
  logic [W-1:0] y0_v       [2];
  logic [W-1:0] y1_v       [2];
`ifdef PERM_OVERRUN_FLAG_EN
  logic         overrun_v  [2];
`endif

  perm_mem_2lane #(.WIDTH(W), .LOGN(LOGN_A)) dut_a (
    .clk     (clk),
    .reset_n (reset_n[0]),
    .next    (next_v[0]),
    .x0      (x0_v[0]),
    .x1      (x1_v[0]),
    .next_out(next_out_v[0]),
    .y0      (y0_v[0]),
    .y1      (y1_v[0])
`ifdef PERM_OVERRUN_FLAG_EN
    ,
    .overrun (overrun_v[0])
`endif
  );

  perm_mem_2lane #(.WIDTH(W), .LOGN(LOGN_B)) dut_b (
    .clk     (clk),
    .reset_n (reset_n[1]),
    .next    (next_v[1]),
    .x0      (x0_v[1]),
    .x1      (x1_v[1]),
    .next_out(next_out_v[1]),
    .y0      (y0_v[1]),
    .y1      (y1_v[1])
`ifdef PERM_OVERRUN_FLAG_EN
    ,
    .overrun (overrun_v[1])
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] exp_q     [2][$];
  int             exp_cyc_q [2][$];
  int             no_q      [2][$];
  logic [2*W-1:0] hold      [2];
  int             last_acc  [2];
  int             ovr_from  [2];
  logic [W-1:0]   frame_w   [NMAX];

  // LOGN=3 reference outputs: frame 0..7 then frame 8..15, pair by pair.
  int lit_tab [16] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};

  task automatic check(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, d, cyc, act, exp);
    end
  endtask

  function automatic int half_of(input int d);
    return (d == 0) ? H_A : H_B;
  endfunction

  // Which input word lands at output position j: evens first, then odds.
  function automatic int perm_pos(input int j, input int h);
    return (j < h) ? 2 * j : 2 * (j - h) + 1;
  endfunction

  task automatic model_reset(input int d);
    exp_q[d].delete();
    exp_cyc_q[d].delete();
    no_q[d].delete();
    hold[d]     = '0;
    last_acc[d] = -1;
    ovr_from[d] = -1;
  endtask

  // Called in the cycle a next pulse is driven; frame_w holds that frame.
  task automatic model_next(input int d);
    int h;
    int t;
    h = half_of(d);
    t = cyc;
    if (last_acc[d] >= 0 && t < last_acc[d] + h) begin
      if (ovr_from[d] < 0) ovr_from[d] = t + 1;
    end else begin
      last_acc[d] = t;
      no_q[d].push_back(t + h + 1);
      for (int c = 0; c < h; c++) begin
        exp_cyc_q[d].push_back(t + h + 2 + c);
        exp_q[d].push_back({frame_w[perm_pos(2 * c, h)], frame_w[perm_pos(2 * c + 1, h)]});
      end
    end
  endtask

  task automatic compare_lane(input int d);
    logic exp_no;
    exp_no = 1'b0;
    if (no_q[d].size() > 0 && no_q[d][0] == cyc) begin
      exp_no = 1'b1;
      void'(no_q[d].pop_front());
    end
    check(d, "next_out", 64'(next_out_v[d]), 64'(exp_no));
    if (exp_cyc_q[d].size() > 0 && exp_cyc_q[d][0] == cyc) begin
      hold[d] = exp_q[d].pop_front();
      void'(exp_cyc_q[d].pop_front());
    end
    check(d, "y_pair", {y0_v[d], y1_v[d]}, hold[d]);
`ifdef PERM_OVERRUN_FLAG_EN
    check(d, "overrun", 64'(overrun_v[d]), 64'(ovr_from[d] >= 0 && cyc >= ovr_from[d]));
`endif
  endtask

  always @(negedge clk) begin : compare
    for (int d = 0; d < 2; d++) compare_lane(d);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_neg(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive nfr frames; gap between frames is 0..gmax cycles after the last
  // write cycle (0 = next on the last write cycle). spur_c >= 0 raises an
  // extra next on that write cycle. Returns in the last write cycle.
  task automatic stream(input int d, input int nfr, input int base, input bit rnd,
                        input int gmax, input int spur_c);
    int h;
    int gap;
    h = half_of(d);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 2 * h; i++)
        frame_w[i] = rnd ? $urandom() : W'(base + f * 2 * h + i);
      next_v[d] = 1'b1;
      model_next(d);
      step();
      next_v[d] = 1'b0;
      for (int c = 0; c < h; c++) begin
        x0_v[d] = frame_w[2 * c];
        x1_v[d] = frame_w[2 * c + 1];
        if (c == spur_c) begin
          next_v[d] = 1'b1;
          model_next(d);
        end
        if (c < h - 1) begin
          step();
          next_v[d] = 1'b0;
        end
      end
      if (f < nfr - 1) begin
        gap = $urandom_range(gmax, 0);
        for (int g = 0; g < gap; g++) begin
          step();
          next_v[d] = 1'b0;
        end
      end
    end
  endtask

  // Hand-computed LOGN=3 expectations for frames starting at t0.
  task automatic lit_run(input int t0, input int nfr);
    for (int k = 5; k <= 5 + 4 * nfr; k++) begin
      wait_neg(t0 + k);
      check(0, "lit_next_out", 64'(next_out_v[0]), 64'(((k - 5) % 4 == 0) && ((k - 5) / 4 < nfr)));
      if (k >= 6)
        check(0, "lit_pair", {y0_v[0], y1_v[0]},
              {32'(lit_tab[2 * (k - 6)]), 32'(lit_tab[2 * (k - 6) + 1])});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0;
      next_v[d]  = 1'b0;
      x0_v[d]    = '0;
      x1_v[d]    = '0;
      model_reset(d);
    end
    repeat (3) step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check(d, "reset_y", {y0_v[d], y1_v[d]}, 64'd0);
      check(d, "reset_next_out", 64'(next_out_v[d]), 64'd0);
    end
    step();
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    repeat (2) step();

    // Single frame 0..7.
    t0 = cyc;
    fork
      stream(0, 1, 0, 1'b0, 0, -1);
      lit_run(t0, 1);
    join
    step();
    repeat (3) step();

    // Back-to-back frames 0..7 and 8..15.
    t0 = cyc;
    fork
      stream(0, 2, 0, 1'b0, 0, -1);
      lit_run(t0, 2);
    join
    step();
    repeat (3) step();

    // Spurious next on the second write cycle.
    stream(0, 1, 32, 1'b0, 0, 1);
`ifdef PERM_OVERRUN_FLAG_EN
    wait_neg(cyc);
    check(0, "lit_overrun", 64'(overrun_v[0]), 64'd1);
    step();
`endif
    repeat (8) step();

    // Reset during the second output pair of a frame.
    t0 = cyc;
    stream(0, 1, 64, 1'b0, 0, -1);
    goto_cycle(t0 + 7);
    reset_n[0] = 1'b0;
    model_reset(0);
    @(negedge clk);
    check(0, "lit_reset_y", {y0_v[0], y1_v[0]}, 64'd0);
    check(0, "lit_reset_next_out", 64'(next_out_v[0]), 64'd0);
    step();
    step();
    reset_n[0] = 1'b1;
    repeat (10) step();
    t0 = cyc;
    fork
      stream(0, 1, 0, 1'b0, 0, -1);
      lit_run(t0, 1);
    join
    step();
    repeat (3) step();

    // LOGN=4: 20 random back-to-back frames, then 10 with idle gaps 0..7.
    stream(1, 20, 0, 1'b1, 0, -1);
    repeat (12) step();
    stream(1, 10, 0, 1'b1, 7, -1);
    repeat (12) step();

    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check(d, "drain_left", 64'(exp_q[d].size() + no_q[d].size()), 64'd0);
    if (N_A != 2 * H_A) check(0, "frame_size", 64'(N_A), 64'(2 * H_A));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
